// File: rtl/vga_fb_ctrl.sv
// ---------------------------------------------------------------------------
// vga_fb_ctrl
//
// Controller for a 2-bit frame buffer RAM that has one synchronous read port
// and one write port.
//   * Generates 640x480@60 VGA timing from a 25 MHz pixel clock.
//   * Streams display reads from an FB_W x FB_H buffer, each stored pixel
//     shown as a 2x2 block on screen.
//   * Shares the RAM write port between a host writer (req/ack) and a
//     built-in clear/fill sequencer using a registered round-robin grant.
//
// Ports
//   clk_25, reset_n          pixel clock, asynchronous active-low reset
//   h_sync, v_sync           active-low syncs, aligned with pixel_out
//   video_on, pixel_out      visible-area flag and pixel to the DAC
//   frame_start              one-cycle pulse while the counters sit at (0,0)
//   fb_rd_addr, fb_q         display read address / data (one-cycle latency)
//   fb_we, fb_wr_addr, fb_data   registered RAM write port
//   host_req/addr/data/ack   host write handshake
//   clear_start/color/busy   fill sequencer control and status
//
// Host handshake: the host raises host_req with host_addr/host_data stable and
// keeps them stable until host_ack. host_ack is high for exactly one cycle,
// and that is the same cycle in which fb_we carries the host write. A request
// still high during the ack cycle is not eligible, so a host that holds
// host_req continuously gets at most one write every two cycles.
// ---------------------------------------------------------------------------
module vga_fb_ctrl #(
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 2
) (
    input  logic              clk_25,
    input  logic              reset_n,
    output logic              h_sync,
    output logic              v_sync,
    output logic              video_on,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              frame_start,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [PIX_W-1:0]  fb_q,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [PIX_W-1:0]  fb_data,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [PIX_W-1:0]  host_data,
    output logic              host_ack,
    input  logic              clear_start,
    input  logic [PIX_W-1:0]  clear_color,
    output logic              clear_busy
);

    // -----------------------------------------------------------------------
    // Timing constants (640x480@60, 800x525 total)
    // -----------------------------------------------------------------------
    localparam logic [9:0] H_LAST     = 10'd799;
    localparam logic [9:0] H_VIS      = 10'd640;
    localparam logic [9:0] H_SYNC_BEG = 10'd656;
    localparam logic [9:0] H_SYNC_END = 10'd751;
    localparam logic [9:0] V_LAST     = 10'd524;
    localparam logic [9:0] V_VIS      = 10'd480;
    localparam logic [9:0] V_SYNC_BEG = 10'd490;
    localparam logic [9:0] V_SYNC_END = 10'd491;

    // Last odd screen line that still moves the row base onto a new buffer
    // row; past it the base stops so it never walks beyond the buffer.
    localparam logic [9:0]        V_ROW_LAST = 10'(2 * FB_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] FILL_LAST  = ADDR_W'(FB_W * FB_H - 1);

    // -----------------------------------------------------------------------
    // Timing counters and display read address
    // -----------------------------------------------------------------------
    logic [9:0]        h_cnt_q, h_cnt_d;
    logic [9:0]        v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              h_sync_q, h_sync_d;
    logic              v_sync_q, v_sync_d;
    logic              video_on_q, video_on_d;
    logic              frame_start_q, frame_start_d;
    logic              vis_next;

    always_comb begin
        h_cnt_d    = h_cnt_q + 10'd1;
        v_cnt_d    = v_cnt_q;
        row_base_d = row_base_q;

        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d    = 10'd0;
                row_base_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
                // Lines come in pairs per buffer row: step the base when
                // leaving an odd line.
                if (v_cnt_q[0] && (v_cnt_q < V_ROW_LAST)) begin
                    row_base_d = row_base_q + ROW_STEP;
                end
            end
        end

        // The read address is registered together with the counters, so it
        // is computed from their next values and always matches h_cnt/v_cnt.
        vis_next  = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
        rd_addr_d = vis_next ? (row_base_d + ADDR_W'(h_cnt_d[9:1])) : '0;

        // Syncs and video_on describe the current counter state but appear
        // one cycle later, in step with fb_q coming back from the RAM.
        h_sync_d   = ~((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q <= H_SYNC_END));
        v_sync_d   = ~((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q <= V_SYNC_END));
        video_on_d = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

        // High exactly while the counters themselves are at (0,0).
        frame_start_d = (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            row_base_q    <= '0;
            rd_addr_q     <= '0;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            row_base_q    <= row_base_d;
            rd_addr_q     <= rd_addr_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    // -----------------------------------------------------------------------
    // Fill sequencer and write-port arbiter
    // -----------------------------------------------------------------------
    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_e;

    fill_state_e       fill_state_q, fill_state_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [PIX_W-1:0]  fill_color_q, fill_color_d;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              ack_q, ack_d;
    logic              last_host_q, last_host_d;   // 1: host was granted last

    logic host_elig;
    logic clr_elig;
    logic grant_host;
    logic grant_clr;

    always_comb begin
        // The host is blocked in its ack cycle, so a held request cannot
        // take two back-to-back slots.
        host_elig = host_req & ~ack_q;
        clr_elig  = (fill_state_q == FILL_RUN);

        // On a tie the requester that was not served last wins.
        grant_host = host_elig & (~clr_elig | ~last_host_q);
        grant_clr  = clr_elig & ~grant_host;

        fill_state_d = fill_state_q;
        fill_addr_d  = fill_addr_q;
        fill_color_d = fill_color_q;

        case (fill_state_q)
            FILL_IDLE: begin
                if (clear_start) begin
                    fill_color_d = clear_color;
                    fill_addr_d  = '0;
                    fill_state_d = FILL_RUN;
                end
            end
            FILL_RUN: begin
                // clear_start is ignored here; only a granted slot advances.
                if (grant_clr) begin
                    if (fill_addr_q == FILL_LAST) begin
                        fill_state_d = FILL_IDLE;
                    end else begin
                        fill_addr_d = fill_addr_q + 1'b1;
                    end
                end
            end
            default: fill_state_d = FILL_IDLE;
        endcase

        // Write port: address and data hold when nobody is granted.
        we_d        = grant_host | grant_clr;
        ack_d       = grant_host;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        last_host_d = last_host_q;
        if (grant_host) begin
            wr_addr_d   = host_addr;
            wr_data_d   = host_data;
            last_host_d = 1'b1;
        end else if (grant_clr) begin
            wr_addr_d   = fill_addr_q;
            wr_data_d   = fill_color_q;
            last_host_d = 1'b0;
        end
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            fill_state_q <= FILL_IDLE;
            fill_addr_q  <= '0;
            fill_color_q <= '0;
            we_q         <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            ack_q        <= 1'b0;
            last_host_q  <= 1'b0;
        end else begin
            fill_state_q <= fill_state_d;
            fill_addr_q  <= fill_addr_d;
            fill_color_q <= fill_color_d;
            we_q         <= we_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            ack_q        <= ack_d;
            last_host_q  <= last_host_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;
    assign fb_rd_addr  = rd_addr_q;
    // fb_q is already a registered RAM output; the delayed video_on gates it.
    assign pixel_out   = video_on_q ? fb_q : '0;

    assign fb_we       = we_q;
    assign fb_wr_addr  = wr_addr_q;
    assign fb_data     = wr_data_q;
    assign host_ack    = ack_q;
    // The fill FSM state is directly visible as clear_busy.
    assign clear_busy  = (fill_state_q == FILL_RUN);

endmodule

// File: doc/vga_fb_ctrl.md
Name: vga_fb_ctrl

Overview:
- Controller for the 2-bit VGA frame buffer RAM: synchronous read, one read port, one write port.
- Generates 640x480@60 timing from clk_25 and sequences display reads from a 320x240 buffer, with each pixel doubled horizontally and vertically.
- Arbitrates the single write port round-robin between a host writer (req/ack) and a built-in clear/fill sequencer.
- Sits between the pixel sources and the frame buffer RAM, and drives the VGA output pins.

Parameters:
- FB_W, 320, frame buffer width in pixels.
- FB_H, 240, frame buffer height in pixels.
- ADDR_W, 17, frame buffer address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
- PIX_W, 2, pixel width in bits.

Ports:
- clk_25  in  1  25 MHz pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- h_sync  out  1  horizontal sync, active low.
- v_sync  out  1  vertical sync, active low.
- video_on  out  1  high while pixel_out carries visible data.
- pixel_out  out  PIX_W  pixel to DAC; 0 outside the visible area.
- frame_start  out  1  one-cycle pulse when h_cnt=0 and v_cnt=0.
- fb_rd_addr  out  ADDR_W  RAM read address.
- fb_q  in  PIX_W  RAM read data, valid 1 cycle after fb_rd_addr.
- fb_we  out  1  RAM write enable.
- fb_wr_addr  out  ADDR_W  RAM write address.
- fb_data  out  PIX_W  RAM write data.
- host_req  in  1  host write request; hold high with addr/data stable until ack.
- host_addr  in  ADDR_W  host write address.
- host_data  in  PIX_W  host write data.
- host_ack  out  1  one-cycle pulse; the write is issued in that same cycle.
- clear_start  in  1  pulse that starts a fill of the whole buffer.
- clear_color  in  PIX_W  fill value, latched at start.
- clear_busy  out  1  high while a fill is in progress.

Behaviour:
- Reset: all outputs 0, except h_sync=1 and v_sync=1. Counters, FSM and round-robin pointer are cleared. Reset mid-fill aborts the fill.
- Timing counters:
  - h_cnt 0..799; v_cnt 0..524, advancing when h_cnt wraps.
  - Visible region: h<640 and v<480.
  - Internal hsync active for h in 656..751; vsync active for v in 490..491.
- Read address: fb_rd_addr = (v_cnt>>1)*FB_W + (h_cnt>>1).
  - Computed incrementally with a row-base register. No multiplier.
  - Held at 0 outside the visible region.
- Output alignment:
  - h_sync, v_sync and video_on are registered one cycle after the counter state, to match RAM latency.
  - pixel_out = fb_q when delayed video_on = 1, else 0.
  - The first visible pixel appears at h_cnt=1 of line 0.
- Clear FSM, IDLE/FILL:
  - IDLE: clear_start latches clear_color, resets the fill address to 0, moves to FILL and sets clear_busy.
  - FILL: requests the write port every cycle. The fill address increments only on a granted cycle.
  - The grant at address FB_W*FB_H-1 returns the FSM to IDLE; clear_busy falls on the next cycle.
  - clear_start during FILL is ignored.
- Arbitration:
  - Host eligible = host_req & ~host_ack, so a host write takes at most one slot every two cycles.
  - One requester eligible: that requester is granted.
  - Both eligible: grant the one not granted last. The pointer resets to "clear last", so the host wins the first tie.
  - Grant is registered: fb_we, fb_wr_addr and fb_data are set on the edge after the request is seen. host_ack pulses in that same cycle.
  - Neither eligible: fb_we=0; address and data hold their previous values.
- Writes and display reads are independent (separate RAM ports); no display stall.

Test Plan:
- Timing after reset: h_sync low for exactly 96 clocks per 800-clock line; v_sync low for 2 lines (1600 clocks) per 525 lines; frame_start period 420000 clocks.
- Read addressing: fb_rd_addr=0 for h_cnt 0..1 of lines 0..1; =1 at h_cnt 2; =320 at h_cnt 0 of line 2; =76799 at h 638..639, v 478..479.
- Display pipeline: fb_q tied to 2'b11 -> pixel_out=3 exactly while delayed video_on=1, and 0 during blanking.
- Host write alone: host_req held with addr 100, data 2 -> fb_we=1, fb_wr_addr=100, fb_data=2, host_ack=1 on one cycle; no second write while req is still held in the ack cycle.
- Clear alone: clear_start with clear_color=1 -> 76800 consecutive fb_we cycles, addresses 0..76799, data 1; clear_busy high for 76800 cycles.
- Contention: clear running with host_req held continuously -> alternating host/clear grants, host first. The host gets one slot per two cycles. A clear_start pulse mid-fill does not restart the address. Asserting reset_n low mid-fill -> clear_busy=0 and fb_we=0 immediately.
